reg_commit_sched: RTL and testbench
===================================

// Module: reg_commit_sched
// PURPOSE
//  Commit-side sequencer for the register file write port in the Tomasulo core. Accepts retiring
//  entries from the ROB head through a valid/ready handshake and buffers them in a small FIFO.
//  Drives exactly one register-file write per cycle and suppresses writes to x0. On a mispredicted
//  commit, it owns the flush sequence: it pulses the ROB-bus reset and stalls the issuer.
// PARAMETERS
//  FIFO_DEPTH    4    commit buffer entries, power of two, >=2
//  REG_ID_W      5    architectural register index width
//  ROB_ID_W      4    ROB tag width; tag 0 = "no producer"
//  XLEN          32   register value width
//  FLUSH_CYCLES  2    cycles reset_to_rob_bus stays high per flush, >=1
// PORTS
//  clk               in   1         single clock, posedge
//  rst               in   1         reset, asynchronous, active-low (0 = reset)
//  rdy               in   1         global enable; 0 freezes all state
//  commit_valid      in   1         ROB head offers an entry
//  commit_ready      out  1         entry accepted when valid&&ready at posedge
//  commit_rd         in   REG_ID_W  destination register
//  commit_dest       in   ROB_ID_W  ROB tag of the retiring entry, nonzero
//  commit_value      in   XLEN      result value
//  commit_miss       in   1         entry is a mispredicted branch; triggers flush
//  rd_to_reg_file    out  REG_ID_W  write-port register index
//  dest_to_reg_file  out  ROB_ID_W  write-port tag (0 = no write)
//  value_to_reg_file out  XLEN      write-port value
//  reset_to_rob_bus  out  1         flush pulse to ROB bus / register-file status
//  issue_stall       out  1         issuer must not rename or issue
//  retired_count     out  32        count of popped entries
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, counters 0. Reset is honoured in any state, including mid-flush.
//  States and transitions:
//   IDLE -> RUN on push.
//   RUN -> IDLE when the FIFO empties and no miss is pending.
//   RUN -> FLUSH on the cycle after the miss entry is popped.
//   FLUSH -> IDLE after FLUSH_CYCLES enabled cycles.
//  commit_ready = rst && rdy && !full && state!=FLUSH && !miss_pending (combinational).
//   A full FIFO never accepts, even if a pop happens in the same cycle.
//  miss_pending sets when a miss entry is pushed; no further pushes until FLUSH completes.
//   The FIFO is therefore empty when FLUSH is entered.
//  Pop: when rdy=1 and the FIFO is non-empty, pop the head each cycle.
//   Write-port outputs are registered: a push into an empty FIFO at edge N appears on the port after edge N+1.
//   Throughput is 1 entry/cycle.
//  Write port is a one-cycle pulse: outputs return to 0 on any cycle with no pop, when rdy=0, and throughout FLUSH.
//  x0 rule: if a popped rd==0, drive rd=0, dest=0, value=0 (no write). retired_count still increments.
//  The miss entry's write is presented the cycle BEFORE reset_to_rob_bus rises. The register file ignores writes while reset is high.
//  FLUSH: reset_to_rob_bus=1 and issue_stall=1 for FLUSH_CYCLES cycles.
//   issue_stall also =1 while miss_pending.
//   Both drop in the cycle after the count expires.
//  rdy=0: no push or pop, flush counter frozen, reset_to_rob_bus/issue_stall hold their values.
//  retired_count: +1 per pop, wraps modulo 2^32.
// STRUCTURE
//  Shared config.v: REG_ID_TYPE, RO_BUFFER_ID_TYPE, REG_TYPE widths; add COMMIT_FIFO_DEPTH and FLUSH_CYCLES defaults.
//  One sub-module: commit_fifo, a synchronous FIFO with async active-low reset.
//   Data = {miss, rd, dest, value}; interface push/pop/full/empty.
//  This block holds the FSM, flush counter, x0 masking, output registers and retired counter.
// TESTING
//  1 Single commit rd=5, dest=3, value=0xDEADBEEF at edge N -> port shows 5/3/0xDEADBEEF after edge N+1 for exactly one cycle; retired_count=1.
//  2 Back-to-back: 6 consecutive valid cycles, DEPTH=4 -> no drops, port order preserved, 1 write/cycle; ready low only while full.
//  3 x0: commit rd=0, dest=7, value=0x55 -> port stays 0/0/0, retired_count +1.
//  4 Miss: entries A(rd=1), B(rd=2, miss), C offered -> C not accepted.
//   A and B written in order; reset_to_rob_bus high 2 cycles starting the cycle after B's write.
//   issue_stall high from B's push until flush ends; ready returns 1 afterwards.
//  5 rdy toggling: rdy=0 for 3 cycles mid-stream and mid-flush -> no pops, port 0, flush counter frozen; sequence resumes intact.
//  6 Async reset asserted mid-FLUSH with 3 entries queued -> immediately all outputs 0, FIFO empty; after release ready=1, state IDLE.

Source files
------------

// File: rtl/reg_commit_sched_pkg.sv
// Shared defaults and FSM encoding for the commit-side register-file write sequencer.
package reg_commit_sched_pkg;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_REG_ID_W     = 5;
  localparam int DEF_ROB_ID_W     = 4;
  localparam int DEF_XLEN         = 32;
  localparam int DEF_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/reg_commit_sched_if.sv
// ROB-head commit handshake: the ROB side is master, the sequencer is slave.
interface reg_commit_sched_if
  import reg_commit_sched_pkg::*;
#(
  parameter int REG_ID_W = DEF_REG_ID_W,
  parameter int ROB_ID_W = DEF_ROB_ID_W,
  parameter int XLEN     = DEF_XLEN
);
  logic                commit_valid;
  logic                commit_ready;
  logic [REG_ID_W-1:0] commit_rd;
  logic [ROB_ID_W-1:0] commit_dest;
  logic [XLEN-1:0]     commit_value;
  logic                commit_miss;

  modport master (
    output commit_valid, commit_rd, commit_dest, commit_value, commit_miss,
    input  commit_ready
  );

  modport slave (
    input  commit_valid, commit_rd, commit_dest, commit_value, commit_miss,
    output commit_ready
  );
endinterface

// File: rtl/reg_commit_sched_commit_fifo.sv
// Synchronous FIFO holding retiring entries; pointers carry a wrap bit for full/empty.
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/reg_commit_sched.sv
// Commit sequencer: buffers ROB retirements, drives one register-file write per cycle,
// and runs the flush sequence after a mispredicted commit.
module reg_commit_sched
  import reg_commit_sched_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int REG_ID_W     = DEF_REG_ID_W,
  parameter int ROB_ID_W     = DEF_ROB_ID_W,
  parameter int XLEN         = DEF_XLEN,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  reg_commit_sched_if.slave   cbus,
  output logic [REG_ID_W-1:0] rd_to_reg_file,
  output logic [ROB_ID_W-1:0] dest_to_reg_file,
  output logic [XLEN-1:0]     value_to_reg_file,
  output logic                reset_to_rob_bus,
  output logic                issue_stall,
  output logic [31:0]         retired_count
);
  localparam int EW = 1 + REG_ID_W + ROB_ID_W + XLEN;
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);

  state_t        state_q;
  logic          miss_pending_q;
  logic          flush_arm_q;
  logic [CW-1:0] flush_cnt_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [EW-1:0] head_wr;

  logic [REG_ID_W-1:0] rd_p1;
  logic [ROB_ID_W-1:0] dest_p1;
  logic [XLEN-1:0]     value_p1;

  // Writes to x0 become an all-zero port (no write), miss flag dropped too.
  function automatic logic [EW-1:0] strip_x0(input logic [EW-1:0] e);
    if (e[XLEN+ROB_ID_W +: REG_ID_W] == '0) return '0;
    return e;
  endfunction

  assign cbus.commit_ready = rst && rdy && !full && (state_q != ST_FLUSH) && !miss_pending_q;
  assign push    = cbus.commit_valid && cbus.commit_ready;
  assign pop     = rdy && !empty;
  assign head_wr = strip_x0(head);

  commit_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cbus.commit_miss, cbus.commit_rd, cbus.commit_dest, cbus.commit_value}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Stage p0 -> p1: popped head registered onto the write port as a one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p1    <= '0;
      dest_p1  <= '0;
      value_p1 <= '0;
    end else if (pop) begin
      rd_p1    <= head_wr[XLEN+ROB_ID_W +: REG_ID_W];
      dest_p1  <= head_wr[XLEN +: ROB_ID_W];
      value_p1 <= head_wr[XLEN-1:0];
    end else begin
      rd_p1    <= '0;
      dest_p1  <= '0;
      value_p1 <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      miss_pending_q <= 1'b0;
      flush_arm_q    <= 1'b0;
      flush_cnt_q    <= '0;
      retired_count  <= '0;
    end else if (rdy) begin
      if (pop) retired_count <= retired_count + 32'd1;
      if (push && cbus.commit_miss) miss_pending_q <= 1'b1;
      // The miss write goes out first; the flush starts on the following enabled edge.
      if (pop && head[EW-1]) flush_arm_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (push) state_q <= ST_RUN;
        ST_RUN: begin
          if (flush_arm_q) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            flush_arm_q <= 1'b0;
          end else if (empty && !push && !miss_pending_q) begin
            state_q <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == CNT_LAST) begin
            state_q        <= ST_IDLE;
            miss_pending_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_to_reg_file    = rd_p1;
  assign dest_to_reg_file  = dest_p1;
  assign value_to_reg_file = value_p1;
  assign reset_to_rob_bus  = (state_q == ST_FLUSH);
  assign issue_stall       = miss_pending_q || (state_q == ST_FLUSH);
endmodule

// File: tb/tb_reg_commit_sched.sv
// Randomized bench for reg_commit_sched against a queue-based model, plus directed scenarios.
module tb_reg_commit_sched;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int TW    = 4;
  localparam int XW    = 32;
  localparam int FC    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  reg_commit_sched_if #(.REG_ID_W(RW), .ROB_ID_W(TW), .XLEN(XW)) cbus ();

  logic [RW-1:0] rd_to_reg_file;
  logic [TW-1:0] dest_to_reg_file;
  logic [XW-1:0] value_to_reg_file;
  logic          reset_to_rob_bus;
  logic          issue_stall;
  logic [31:0]   retired_count;

  reg_commit_sched #(
    .FIFO_DEPTH(DEPTH), .REG_ID_W(RW), .ROB_ID_W(TW), .XLEN(XW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .cbus              (cbus),
    .rd_to_reg_file    (rd_to_reg_file),
    .dest_to_reg_file  (dest_to_reg_file),
    .value_to_reg_file (value_to_reg_file),
    .reset_to_rob_bus  (reset_to_rob_bus),
    .issue_stall       (issue_stall),
    .retired_count     (retired_count)
  );

  typedef struct packed {
    logic          miss;
    logic [RW-1:0] rd;
    logic [TW-1:0] dest;
    logic [XW-1:0] val;
  } ent_t;

  // Model: queued entries, pending-miss flag, remaining flush cycles, expected port.
  ent_t          q[$];
  bit            m_mp;
  bit            m_arm;
  int            m_flush;
  logic [RW-1:0] e_rd;
  logic [TW-1:0] e_dest;
  logic [XW-1:0] e_val;
  logic [31:0]   e_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return rst && rdy && (q.size() < DEPTH) && (m_flush == 0) && !m_mp;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mp = 0; m_arm = 0; m_flush = 0;
    e_rd = '0; e_dest = '0; e_val = '0; e_cnt = '0;
  endtask

  task automatic model_step();
    bit   acc;
    ent_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    e_rd = '0; e_dest = '0; e_val = '0;
    if (!rdy) return;
    acc = cbus.commit_valid && m_ready();
    if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) m_mp = 0;
    end else if (m_arm) begin
      m_flush = FC;
      m_arm = 0;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      e_cnt = e_cnt + 32'd1;
      if (e.rd != 0) begin
        e_rd = e.rd; e_dest = e.dest; e_val = e.val;
      end
      if (e.miss) m_arm = 1;
    end
    if (acc) begin
      q.push_back({cbus.commit_miss, cbus.commit_rd, cbus.commit_dest, cbus.commit_value});
      if (cbus.commit_miss) m_mp = 1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ready",     32'(cbus.commit_ready),     32'(m_ready()));
      chk("rd",        32'(rd_to_reg_file),        32'(e_rd));
      chk("dest",      32'(dest_to_reg_file),      32'(e_dest));
      chk("value",     value_to_reg_file,          e_val);
      chk("rob_reset", 32'(reset_to_rob_bus),      32'(m_flush > 0));
      chk("stall",     32'(issue_stall),           32'(m_mp || (m_flush > 0)));
      chk("retired",   retired_count,              e_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic offer(input bit v, input bit miss, input logic [RW-1:0] r,
                       input logic [TW-1:0] d, input logic [XW-1:0] val);
    cbus.commit_valid = v;
    cbus.commit_miss  = miss;
    cbus.commit_rd    = r;
    cbus.commit_dest  = d;
    cbus.commit_value = val;
  endtask

  initial begin
    logic [RW-1:0] r;
    model_reset();
    offer(0, 0, '0, '0, '0);
    repeat (3) cyc();
    cmp_on = 1;
    chk("rst_rd",      32'(rd_to_reg_file), 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    chk("rst_ready",   32'(cbus.commit_ready), 32'd0);
    rst = 1; rdy = 1;
    cyc();

    // Single commit: visible after the edge following the push, for one cycle.
    offer(1, 0, 5'd5, 4'd3, 32'hDEADBEEF);
    cyc();
    offer(0, 0, '0, '0, '0);
    cyc();
    chk("t1_rd",      32'(rd_to_reg_file), 32'd5);
    chk("t1_dest",    32'(dest_to_reg_file), 32'd3);
    chk("t1_value",   value_to_reg_file, 32'hDEADBEEF);
    chk("t1_retired", retired_count, 32'd1);
    cyc();
    chk("t1_pulse",   32'(rd_to_reg_file), 32'd0);

    // Back-to-back commits.
    for (int i = 0; i < 6; i++) begin
      offer(1, 0, 5'(i + 8), 4'(i + 1), 32'(i * 32'h1111));
      chk("t2_ready", 32'(cbus.commit_ready), 32'd1);
      cyc();
    end
    offer(0, 0, '0, '0, '0);
    repeat (3) cyc();
    chk("t2_retired", retired_count, 32'd7);

    // Write to x0 is suppressed but still retires.
    offer(1, 0, 5'd0, 4'd7, 32'h55);
    cyc();
    offer(0, 0, '0, '0, '0);
    cyc();
    chk("t3_dest",    32'(dest_to_reg_file), 32'd0);
    chk("t3_value",   value_to_reg_file, 32'd0);
    chk("t3_retired", retired_count, 32'd8);
    cyc();

    // Miss: A, B(miss), C offered but refused; flush follows B's write.
    offer(1, 0, 5'd1, 4'd1, 32'hA);
    cyc();
    offer(1, 1, 5'd2, 4'd2, 32'hB);
    cyc();
    chk("t4_a_rd",   32'(rd_to_reg_file), 32'd1);
    chk("t4_stall",  32'(issue_stall), 32'd1);
    chk("t4_ready0", 32'(cbus.commit_ready), 32'd0);
    offer(1, 0, 5'd3, 4'd3, 32'hC);
    cyc();
    chk("t4_b_rd",   32'(rd_to_reg_file), 32'd2);
    chk("t4_norst",  32'(reset_to_rob_bus), 32'd0);
    cyc();
    chk("t4_rst1",   32'(reset_to_rob_bus), 32'd1);
    chk("t4_port0",  32'(rd_to_reg_file), 32'd0);
    cyc();
    chk("t4_rst2",   32'(reset_to_rob_bus), 32'd1);
    cyc();
    offer(0, 0, '0, '0, '0);
    chk("t4_rstoff", 32'(reset_to_rob_bus), 32'd0);
    chk("t4_stoff",  32'(issue_stall), 32'd0);
    chk("t4_ready1", 32'(cbus.commit_ready), 32'd1);
    chk("t4_retired", retired_count, 32'd10);
    cyc();

    // rdy low during a flush freezes it.
    offer(1, 1, 5'd4, 4'd4, 32'h44);
    cyc();
    offer(0, 0, '0, '0, '0);
    cyc();
    cyc();
    rdy = 0;
    repeat (3) cyc();
    chk("t5_frozen", 32'(reset_to_rob_bus), 32'd1);
    rdy = 1;
    cyc();
    chk("t5_rst_last", 32'(reset_to_rob_bus), 32'd1);
    cyc();
    chk("t5_done", 32'(reset_to_rob_bus), 32'd0);

    // Asynchronous reset in the middle of a flush.
    offer(1, 1, 5'd6, 4'd6, 32'h66);
    cyc();
    offer(0, 0, '0, '0, '0);
    cyc();
    cyc();
    chk("t6_inflush", 32'(reset_to_rob_bus), 32'd1);
    #1 rst = 0;
    #1;
    model_reset();
    chk("t6_rob_rst", 32'(reset_to_rob_bus), 32'd0);
    chk("t6_stall",   32'(issue_stall), 32'd0);
    chk("t6_retired", retired_count, 32'd0);
    repeat (2) cyc();
    rst = 1;
    cyc();
    chk("t6_ready", 32'(cbus.commit_ready), 32'd1);

    // Random traffic with rdy gaps, misses, x0 writes and occasional resets.
    for (int n = 0; n < 800; n++) begin
      rdy = ($urandom % 4) != 0;
      r = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
      offer(($urandom % 3) != 0, ($urandom % 12) == 0, r,
            4'($urandom_range(1, 15)), $urandom);
      if (($urandom % 200) == 0) begin
        #1 rst = 0;
        #1 model_reset();
        cyc();
        rst = 1;
      end
      cyc();
    end
    offer(0, 0, '0, '0, '0);
    rdy = 1;
    repeat (10) cyc();
    cmp_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
